// File: rtl/oled_refresh_scheduler.sv
// oled_refresh_scheduler
// Byte-stream scheduler for the SSD1309 SPI path. It streams full frames page
// by page (a 3-byte address header followed by COLUMNS display bytes per page)
// and inserts single user command bytes only in IDLE or between pages.
//
// Handshake: a byte transfers in any cycle where tx_valid && tx_ready. Once
// tx_valid is raised, tx_valid, tx_data and tx_dc hold until that cycle.
//
// Optional feature macro: OLED_SCHED_AUTO_REFRESH_EN. When defined, a free
// running counter requests a frame every REFRESH_DIV cycles.
//
// state_dbg mirrors the FSM state encoding (0 IDLE, 1 CMD, 2 HDR, 3 FETCH,
// 4 DATA, 5 DONE).
module oled_refresh_scheduler #(
  parameter int PAGES       = 8,
  parameter int COLUMNS     = 128,
  parameter int REFRESH_DIV = 450000,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_done,
  input  logic          frame_req,
  input  logic          cmd_req,
  input  logic [7:0]    cmd_byte,
  output logic          cmd_ack,
  output logic [AW-1:0] fb_rd_addr,
  input  logic [7:0]    fb_rd_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_dc,
  input  logic          tx_ready,
  output logic          frame_busy,
  output logic          frame_done,
  output logic [2:0]    state_dbg
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLUMNS - 1);

  // Reject configurations the address bus or tick counter cannot represent.
  if (((2 ** AW) < (PAGES * COLUMNS)) || (REFRESH_DIV < 1)) begin : g_cfg_check
    $error("oled_refresh_scheduler: AW too small or REFRESH_DIV < 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_HDR   = 3'd2,
    S_FETCH = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    hdr_q, hdr_d;
  logic          ret_hdr_q, ret_hdr_d;
  logic          frame_pend_q;
  logic          start_frame;
  logic          refresh_tick;

  assign state_dbg = state_q;

`ifdef OLED_SCHED_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] TICK_AT = RW'(REFRESH_DIV - 1);
  logic [RW-1:0] ref_cnt_q;

  // Free-running divider; the tick fires on the last count of each period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt_q <= '0;
    end else if (ref_cnt_q == TICK_AT) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_q + RW'(1);
    end
  end

  assign refresh_tick = (ref_cnt_q == TICK_AT);
`else
  assign refresh_tick = 1'b0;
`endif

  // Next-state and tx interface decode. A command waits while cmd_ack is
  // still high so a requester that drops cmd_req on seeing the ack is not
  // served twice.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    col_d       = col_q;
    hdr_d       = hdr_q;
    ret_hdr_d   = ret_hdr_q;
    start_frame = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    tx_dc       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (init_done) begin
          if (cmd_req && !cmd_ack) begin
            ret_hdr_d = 1'b0;
            state_d   = S_CMD;
          end else if (frame_pend_q) begin
            start_frame = 1'b1;
            page_d      = '0;
            hdr_d       = 2'd0;
            state_d     = S_HDR;
          end
        end
      end
      S_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_byte;
        if (tx_ready) begin
          hdr_d   = 2'd0;
          state_d = ret_hdr_q ? S_HDR : S_IDLE;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        case (hdr_q)
          2'd0:    tx_data = 8'hB0 | 8'(page_q);
          2'd1:    tx_data = 8'h00;
          default: tx_data = 8'h10;
        endcase
        if (tx_ready) begin
          if (hdr_q == 2'd2) begin
            col_d   = '0;
            state_d = S_FETCH;
          end else begin
            hdr_d = hdr_q + 2'd1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        // The read address is held through DATA, so the RAM keeps returning
        // the same byte while the transmitter stalls.
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = fb_rd_data;
        if (tx_ready) begin
          if (col_q != LAST_COL) begin
            col_d   = col_q + CW'(1);
            state_d = S_FETCH;
          end else if (page_q != LAST_PAGE) begin
            page_d = page_q + PW'(1);
            hdr_d  = 2'd0;
            if (cmd_req && !cmd_ack) begin
              ret_hdr_d = 1'b1;
              state_d   = S_CMD;
            end else begin
              state_d = S_HDR;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      page_q    <= '0;
      col_q     <= '0;
      hdr_q     <= 2'd0;
      ret_hdr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      col_q     <= col_d;
      hdr_q     <= hdr_d;
      ret_hdr_q <= ret_hdr_d;
    end
  end

  // One-deep frame request latch; a request landing on the start cycle
  // re-arms it so that frame is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_pend_q <= 1'b0;
    end else if (frame_req || refresh_tick) begin
      frame_pend_q <= 1'b1;
    end else if (start_frame) begin
      frame_pend_q <= 1'b0;
    end
  end

  // Registered status pulses and frame activity flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ack    <= 1'b0;
      frame_done <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      cmd_ack    <= (state_q == S_CMD) && tx_ready;
      frame_done <= (state_d == S_DONE);
      if (start_frame) begin
        frame_busy <= 1'b1;
      end else if (state_d == S_DONE) begin
        frame_busy <= 1'b0;
      end
    end
  end

  // Framebuffer address is loaded on entry to FETCH and held through DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_rd_addr <= '0;
    end else if (state_d == S_FETCH) begin
      fb_rd_addr <= AW'(int'(page_d) * COLUMNS + int'(col_d));
    end
  end

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Directed bench for oled_refresh_scheduler. The framebuffer model returns
// addr[7:0] one cycle after the address; accepted tx bytes are logged as
// {dc, data} together with the cycle they transferred in.
module tb_oled_refresh_scheduler;

  localparam int PAGES      = 8;
  localparam int COLUMNS    = 128;
  localparam int AW         = 10;
  localparam int FRAME_LEN  = PAGES * (3 + COLUMNS);

  logic          clk;
  logic          reset;
  logic          init_done;
  logic          frame_req;
  logic          cmd_req;
  logic [7:0]    cmd_byte;
  logic          cmd_ack;
  logic [AW-1:0] fb_rd_addr;
  logic [7:0]    fb_rd_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_dc;
  logic          tx_ready;
  logic          frame_busy;
  logic          frame_done;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] log_q[$];
  int         log_cyc[$];
  logic [8:0] exp_q[$];
  int         done_cnt = 0;
  int         ack_cnt = 0;
  bit         valid_seen = 0;

  oled_refresh_scheduler #(
    .PAGES(PAGES), .COLUMNS(COLUMNS), .REFRESH_DIV(5000), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .frame_req(frame_req),
    .cmd_req(cmd_req), .cmd_byte(cmd_byte), .cmd_ack(cmd_ack),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .frame_busy(frame_busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer model: content equals the low address byte
  always @(posedge clk) fb_rd_data <= fb_rd_addr[7:0];

  // Passive logger, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (tx_valid && tx_ready) begin
        log_q.push_back({tx_dc, tx_data});
        log_cyc.push_back(cyc);
      end
      if (frame_done) done_cnt++;
      if (cmd_ack) ack_cnt++;
      if (tx_valid) valid_seen = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_req();
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
    exp_q.delete();
    done_cnt = 0;
    ack_cnt = 0;
  endtask

  task automatic wait_log(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int bound, output bit ok, output int at_cyc);
    ok = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cmd_ack) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream of one frame, optionally with a command byte
  // inserted before the header of page cmd_page (cmd_page < 0: none).
  task automatic push_frame_exp(input int cmd_page, input logic [7:0] cmd);
    for (int p = 0; p < PAGES; p++) begin
      if (p == cmd_page) exp_q.push_back({1'b0, cmd});
      exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h010);
      for (int c = 0; c < COLUMNS; c++) exp_q.push_back({1'b1, 8'((p * COLUMNS + c) % 256)});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    init_done = 1'b0;
    frame_req = 1'b0;
    cmd_req = 1'b0;
    cmd_byte = 8'h00;
    tx_ready = 1'b1;
    tick(3);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_dc !== 1'b0) begin errors++; $display("FAIL reset_tx_dc: got %b want 0", tx_dc); end
    checks++; if (fb_rd_addr !== '0) begin errors++; $display("FAIL reset_fb_rd_addr: got %h want 0", fb_rd_addr); end
    checks++; if (cmd_ack !== 1'b0) begin errors++; $display("FAIL reset_cmd_ack: got %b want 0", cmd_ack); end
    checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_frame_busy: got %b want 0", frame_busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    int first_bad;
    clear_log();
    init_done = 1'b1;
    tx_ready = 1'b1;
    push_frame_exp(-1, 8'h00);
    pulse_frame_req();
    wait_log(500, 3000, ok);
    checks++; if (frame_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_mid: got %b want 1", frame_busy); end
    wait_done(1, 3000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL frame_done_timeout: got no frame_done within bound"); end
    checks++; if (log_q.size() != FRAME_LEN) begin errors++; $display("FAIL frame_len: got %0d want %0d", log_q.size(), FRAME_LEN); end
    if (log_q.size() >= FRAME_LEN) begin
      checks++; if (log_q[0] !== 9'h0B0) begin errors++; $display("FAIL frame_hdr0: got %h want 0b0", log_q[0]); end
      checks++; if (log_q[2] !== 9'h010) begin errors++; $display("FAIL frame_hdr2: got %h want 010", log_q[2]); end
      checks++; if (log_q[3 + 127] !== 9'h17F) begin errors++; $display("FAIL frame_page0_last: got %h want 17f", log_q[130]); end
      checks++; if (log_q[7 * 131] !== 9'h0B7) begin errors++; $display("FAIL frame_page7_hdr: got %h want 0b7", log_q[7 * 131]); end
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (log_q[i] !== exp_q[i]) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL frame_bytes: %0d wrong, first at %0d got %h want %h", bad, first_bad, log_q[first_bad], exp_q[first_bad]); end
      checks++; if (log_cyc[FRAME_LEN - 1] - log_cyc[0] != 2071) begin errors++; $display("FAIL frame_byte_span: got %0d want 2071", log_cyc[FRAME_LEN - 1] - log_cyc[0]); end
    end
    checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b want 0", frame_busy); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_frame_latency();
    bit ok;
    int done_at;
    clear_log();
    pulse_frame_req();
    done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        done_at = cyc;
        break;
      end
    end
    tick(1);
    ok = (done_at >= 0) && (log_cyc.size() > 0);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL latency_timeout: got no frame_done"); end
    if (ok) begin
      // first header byte is sent the cycle after IDLE is left
      checks++; if (done_at - (log_cyc[0] - 1) != 2073) begin errors++; $display("FAIL frame_latency: got %0d want 2073", done_at - (log_cyc[0] - 1)); end
    end
  endtask

  task automatic test_cmd_idle();
    bit ok;
    int start;
    int at;
    clear_log();
    start = cyc;
    cmd_byte = 8'h3C;
    cmd_req = 1'b1;
    wait_ack(10, ok, at);
    cmd_req = 1'b0;
    tick(5);
    checks++; if (at - start != 2) begin errors++; $display("FAIL cmd_latency: got %0d want 2", at - start); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL cmd_len: got %0d want 1", log_q.size()); end
    if (log_q.size() >= 1) begin
      checks++; if (log_q[0] !== 9'h03C) begin errors++; $display("FAIL cmd_byte: got %h want 03c", log_q[0]); end
    end
    checks++; if (ack_cnt != 1) begin errors++; $display("FAIL cmd_ack_count: got %0d want 1", ack_cnt); end
  endtask

  task automatic test_cmd_with_frame();
    bit ok;
    int at;
    clear_log();
    cmd_byte = 8'hA5;
    cmd_req = 1'b1;
    pulse_frame_req();
    wait_ack(10, ok, at);
    cmd_req = 1'b0;
    wait_done(1, 3000, ok);
    checks++; if (log_q.size() != FRAME_LEN + 1) begin errors++; $display("FAIL both_len: got %0d want %0d", log_q.size(), FRAME_LEN + 1); end
    if (log_q.size() >= 2) begin
      checks++; if (log_q[0] !== 9'h0A5) begin errors++; $display("FAIL both_first: got %h want 0a5", log_q[0]); end
      checks++; if (log_q[1] !== 9'h0B0) begin errors++; $display("FAIL both_second: got %h want 0b0", log_q[1]); end
    end
  endtask

  task automatic test_cmd_mid_frame();
    bit ok;
    int at;
    int bad;
    clear_log();
    push_frame_exp(3, 8'h81);
    pulse_frame_req();
    wait_log(2 * 131 + 3 + 15, 3000, ok);
    cmd_byte = 8'h81;
    cmd_req = 1'b1;
    wait_ack(400, ok, at);
    cmd_req = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_cmd_ack_timeout: got no cmd_ack"); end
    wait_done(1, 3000, ok);
    checks++; if (log_q.size() != FRAME_LEN + 1) begin errors++; $display("FAIL mid_len: got %0d want %0d", log_q.size(), FRAME_LEN + 1); end
    if (log_q.size() >= FRAME_LEN + 1) begin
      checks++; if (log_q[393] !== 9'h081) begin errors++; $display("FAIL mid_cmd_pos: got %h want 081", log_q[393]); end
      checks++; if (log_q[394] !== 9'h0B3) begin errors++; $display("FAIL mid_next_hdr: got %h want 0b3", log_q[394]); end
      bad = 0;
      for (int i = 0; i < FRAME_LEN + 1; i++) if (log_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_stream: got %0d wrong bytes want 0", bad); end
    end
    checks++; if (ack_cnt != 1) begin errors++; $display("FAIL mid_ack_count: got %0d want 1", ack_cnt); end
  endtask

  task automatic test_backpressure();
    int viol;
    int bad;
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_dc;
    bit done;
    clear_log();
    push_frame_exp(-1, 8'h00);
    viol = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    prev_dc = 1'b0;
    done = 1'b0;
    pulse_frame_req();
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_dc !== prev_dc)) viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_dc = tx_dc;
      if (done_cnt != 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    tick(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_timeout: got no frame_done"); end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_stability: got %0d changes while stalled want 0", viol); end
    checks++; if (log_q.size() != FRAME_LEN) begin errors++; $display("FAIL bp_len: got %0d want %0d", log_q.size(), FRAME_LEN); end
    if (log_q.size() == FRAME_LEN) begin
      bad = 0;
      for (int i = 0; i < FRAME_LEN; i++) if (log_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_bytes: got %0d wrong want 0", bad); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    pulse_frame_req();
    wait_log(10, 100, ok);
    for (int k = 0; k < 3; k++) begin
      pulse_frame_req();
      tick(5);
    end
    wait_done(2, 6000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got %0d frame_done want 2", done_cnt); end
    tick(2500);
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    checks++; if (log_q.size() != 2 * FRAME_LEN) begin errors++; $display("FAIL b2b_len: got %0d want %0d", log_q.size(), 2 * FRAME_LEN); end
    if (log_q.size() > FRAME_LEN) begin
      checks++; if (log_q[FRAME_LEN] !== 9'h0B0) begin errors++; $display("FAIL b2b_second_hdr: got %h want 0b0", log_q[FRAME_LEN]); end
    end
  endtask

  task automatic test_init_and_abort();
    bit ok;
    clear_log();
    init_done = 1'b0;
    valid_seen = 1'b0;
    pulse_frame_req();
    tick(50);
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL init_gate_valid: got tx_valid=1 want 0"); end
    init_done = 1'b1;
    wait_log(1, 20, ok);
    checks++; if (ok !== 1'b1 || log_q[0] !== 9'h0B0) begin errors++; $display("FAIL init_start: got ok=%b want first byte 0b0", ok); end
    wait_log(131 + 5, 500, ok);
    init_done = 1'b0;
    wait_log(4 * 131 + 20, 2000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_drop_mid_frame: got %0d bytes want >= %0d", log_q.size(), 4 * 131 + 20); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00 || tx_dc !== 1'b0) begin errors++; $display("FAIL abort_tx_byte: got dc=%b data=%h want 0/00", tx_dc, tx_data); end
    checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", frame_busy); end
    checks++; if (fb_rd_addr !== '0) begin errors++; $display("FAIL abort_addr: got %h want 0", fb_rd_addr); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", state_dbg); end
    tick(1);
    reset = 1'b1;
    init_done = 1'b1;
    clear_log();
    tick(30);
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL abort_no_pending: got %0d bytes want 0", log_q.size()); end
  endtask

`ifdef OLED_SCHED_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    bit ok;
    int rel;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    init_done = 1'b1;
    rel = cyc;
    clear_log();
    wait_done(2, 12000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL auto_timeout: got %0d frames want 2", done_cnt); end
    checks++; if (log_q.size() < 2 * FRAME_LEN) begin errors++; $display("FAIL auto_len: got %0d want >= %0d", log_q.size(), 2 * FRAME_LEN); end
    if (log_q.size() >= 2 * FRAME_LEN) begin
      checks++; if (log_q[FRAME_LEN] !== 9'h0B0) begin errors++; $display("FAIL auto_second_hdr: got %h want 0b0", log_q[FRAME_LEN]); end
      checks++; if (log_cyc[FRAME_LEN] - log_cyc[0] != 5000) begin errors++; $display("FAIL auto_period: got %0d want 5000", log_cyc[FRAME_LEN] - log_cyc[0]); end
      checks++; if (log_cyc[0] - rel != 5001) begin errors++; $display("FAIL auto_first: got %0d want 5001", log_cyc[0] - rel); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
`ifdef OLED_SCHED_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_frame();
    test_frame_latency();
    test_cmd_idle();
    test_cmd_with_frame();
    test_cmd_mid_frame();
    test_backpressure();
    test_back_to_back();
    test_init_and_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_refresh_scheduler.md
# oled_refresh_scheduler

Sequences and arbitrates the byte stream feeding the SSD1309 OLED SPI path. Sits between the framebuffer RAM, a user command requester and the byte-level SPI transmitter inside `ssd1309_driver`. Once the panel power-up sequence is complete it streams whole frames page by page, each page preceded by addressing commands. Single user command bytes are slotted in only at page boundaries.

## Interface
- `PAGES`, 8: display pages (8 rows each)
- `COLUMNS`, 128: columns per page; framebuffer depth = `PAGES*COLUMNS`
- `REFRESH_DIV`, 450000: clk cycles between auto-refresh ticks (only used with the macro below)
- `AW`, 10: framebuffer address width, must satisfy 2^AW >= `PAGES*COLUMNS`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `init_done`  in  1  panel power-up/init sequence finished; scheduler stays in IDLE while low
- `frame_req`  in  1  single-cycle pulse requesting one full frame refresh
- `cmd_req`  in  1  user command pending; held until acked
- `cmd_byte`  in  8  user command byte; stable while `cmd_req` is high
- `cmd_ack`  out  1  one-cycle pulse; the command byte was accepted onto the tx interface
- `fb_rd_addr`  out  AW  framebuffer read address
- `fb_rd_data`  in  8  read data, valid exactly 1 cycle after the address
- `tx_valid`  out  1  byte available to transmitter
- `tx_data`  out  8  byte to send
- `tx_dc`  out  1  0 = command, 1 = display data
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid && tx_ready`
- `frame_busy`  out  1  high from first page header byte to last data byte accepted
- `frame_done`  out  1  one-cycle pulse after the last data byte of a frame is accepted

## Operation
- States: IDLE, CMD, HDR, FETCH, DATA, DONE.
- IDLE:
  - Requires `init_done = 1`.
  - With `cmd_req` high, go to CMD. Commands take priority over a pending frame.
  - Otherwise, with `frame_pend` set, clear it, set page = 0 and go to HDR.
- `frame_pend`:
  - Set by `frame_req` (or an auto tick); one deep.
  - Requests that arrive while it is already set are dropped.
  - Requests that arrive while `frame_busy` is high set it, so exactly one frame follows.
- CMD:
  - Drive `tx_data = cmd_byte`, `tx_dc = 0`, `tx_valid = 1`.
  - On handshake, pulse `cmd_ack` and return to the state that was interrupted: IDLE, or HDR of the next page.
- HDR:
  - Send 3 command bytes in order: `0xB0|page`, `0x00`, `0x10`. Each is held until its handshake.
  - After the third, set column = 0 and go to FETCH.
- FETCH:
  - Drive `fb_rd_addr = page*COLUMNS + column` with `tx_valid = 0` for one cycle.
  - Next cycle go to DATA.
- DATA:
  - Register `fb_rd_data` into `tx_data`, with `tx_dc = 1` and `tx_valid = 1`.
  - On handshake:
    - If column < COLUMNS-1, increment column and go to FETCH.
    - Else if page < PAGES-1, increment page and go to HDR, or to CMD first if `cmd_req` is high.
    - Else go to DONE.
- DONE: pulse `frame_done`, drop `frame_busy`, go to IDLE.
- A user command never splits a page's header or data run. It is checked only in IDLE and between pages.
- `init_done` falling mid-frame has no effect until the frame completes. Afterwards the scheduler holds in IDLE.
- Counters are sized to the parameters; page and column never wrap inside a frame.

## Timing
- Reset values: `tx_valid = 0`, `tx_data = 0x00`, `tx_dc = 0`, `fb_rd_addr = 0`, `cmd_ack = 0`, `frame_busy = 0`, `frame_done = 0`, `frame_pend = 0`, state IDLE.
- Reset asserted mid-frame aborts immediately. No partial byte is retained and the pending frame is cleared.
- `tx_data` and `tx_dc` are stable whenever `tx_valid` is high, until the handshake. `tx_valid` never drops without a handshake.
- With `tx_ready` tied high:
  - A frame takes PAGES*(3 + 2*COLUMNS) + 1 cycles from leaving IDLE to the `frame_done` pulse. That is 2073 cycles at the defaults.
  - A command takes 2 cycles from IDLE (`cmd_req` high) to `cmd_ack`.
- `frame_req` and `cmd_req` arriving in the same cycle in IDLE: the command goes first, then the frame.
- `cmd_ack` and `frame_done` are registered, one cycle wide.

## Configuration
- `OLED_SCHED_AUTO_REFRESH_EN` defined:
  - An internal counter pulses a refresh tick every `REFRESH_DIV` cycles. It counts from 0 after reset.
  - The tick is OR'd with `frame_req` into `frame_pend`.
- Not defined: no counter is built, `REFRESH_DIV` is unused, and frames start only from `frame_req`.

## Test plan
- Defaults, `tx_ready` = 1, `init_done` = 1, framebuffer holding addr[7:0]; pulse `frame_req` -> first bytes B0, 00, 10 with dc = 0, then 00..7F with dc = 1; the page 7 header is B7, 00, 10; `frame_done` arrives 2073 cycles after IDLE exit.
- `cmd_req` with `0x81` raised during page 2 data -> it appears with dc = 0 after page 2's last data byte and before B3; `cmd_ack` pulses once.
- `tx_ready` toggling randomly -> `tx_data` and `tx_dc` never change while `tx_valid` is high without `tx_ready`; the byte count per frame is exactly 1048.
- Three `frame_req` pulses during a busy frame -> exactly one additional frame follows; `frame_done` pulses twice in total.
- `init_done` = 0 with `frame_req` -> `tx_valid` stays 0; raising `init_done` starts the frame. Reset asserted mid-page 4 -> all outputs go to reset values within the same cycle (asynchronously).
- With `OLED_SCHED_AUTO_REFRESH_EN`, `REFRESH_DIV` = 5000 -> frames start every 5000 cycles with no `frame_req`.
